conv_slice: RTL and testbench
=============================

# conv_slice

Parametrised successor to the fixed three-tap convolution slice. It computes a signed dot product of `MAC_NB` image lanes against `MAC_NB` stored weights through a systolic chain of `multiply_add` stages, seeded with a programmable bias. The result is requantised (rounding shift, optional ReLU, saturation) to `OUT_WIDTH`. Weights load serially through a ready/valid handshake under a small FSM. The block sits between the line-buffer/window generator and the channel accumulator.

## Interface
- `MAC_NB`, 3: kernel taps (lanes) per slice, ≥1.
- `IMAGE_WIDTH`, 16: signed image sample width.
- `WEIGHT_WIDTH`, 16: signed weight width.
- `MAC_LAT`, 5: `multiply_add` latency in cycles.
- `OUT_WIDTH`, 16: signed output width.
- `SHIFT`, 0: requantisation right-shift, 0..`ACC_WIDTH`-1.
- localparam `ACC_WIDTH` = `IMAGE_WIDTH`+`WEIGHT_WIDTH`+$clog2(`MAC_NB`)+1.
- localparam `STAGE` = `MAC_LAT`+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_bias` in `ACC_WIDTH`: signed bias, sampled with each accepted image.
- `cfg_relu` in 1: clamp negative results to 0; sampled with each accepted image.
- `weight` in `WEIGHT_WIDTH`: weight word for the current load index.
- `weight_valid` in 1.
- `weight_ready` out 1: high only in LOAD.
- `weight_clear` in 1: request to reload weights.
- `weight_loaded` out 1: high in READY.
- `image` in `IMAGE_WIDTH`*`MAC_NB`: lane x at `[x*IMAGE_WIDTH +: IMAGE_WIDTH]`.
- `image_valid` in 1: no backpressure.
- `result` out `OUT_WIDTH`: 0 whenever `result_valid` is low.
- `result_valid` out 1.
- `err_drop` out 1: sticky; set when an image is dropped, cleared only by reset.

## Operation
- FSM states:
  - LOAD: each `weight_valid`&&`weight_ready` writes `weight` to tap `idx` and increments `idx`. Accepting tap `MAC_NB`-1 moves the FSM to READY.
  - READY: `image_valid` is accepted. `weight_clear` moves the FSM to DRAIN.
  - DRAIN: waits until no accepted image is in flight (`busy` low), then enters LOAD with `idx`=0.
- An `image_valid` seen outside READY is dropped and sets `err_drop`. This includes the cycle in which the last weight is accepted.
- `weight_clear` in LOAD resets `idx` to 0, and the coincident weight is not captured. `weight_clear` in DRAIN has no effect.
- Datapath:
  - Tap x multiplies lane x, delayed `STAGE`*x cycles, by weight x.
  - Tap x adds the registered partial sum of tap x-1. Tap 0 adds the bias delayed to align.
  - All arithmetic is signed two's complement in `ACC_WIDTH` with no internal overflow.
- Requant (registered):
  - Add 2^(`SHIFT`-1) when `SHIFT`>0, then arithmetic shift right by `SHIFT`.
  - Apply ReLU if the sampled `cfg_relu` is set.
  - Saturate to [−2^(`OUT_WIDTH`-1), 2^(`OUT_WIDTH`-1)−1].
- `busy` = OR of all in-flight valid bits.

## Timing
- Image accepted at cycle t → `result_valid` at t+`STAGE`*`MAC_NB`+1, which is 19 at defaults.
- Full throughput: one image per cycle. Results appear in order, one per accepted image.
- `weight_loaded` rises the cycle after the last weight is accepted.
- DRAIN→LOAD happens the cycle after `busy` falls. `weight_ready` rises on that same edge.
- Reset values: FSM LOAD, `idx` 0, weights 0, all valid pipelines 0, `result` 0, `result_valid` 0, `err_drop` 0, `weight_ready` 1, `weight_loaded` 0.
- Reset mid-stream discards in-flight data. No `result_valid` follows the reset.

## Structure
- Package `conv_pkg` holds:
  - the `slice_state_t` enum {LOAD, READY, DRAIN};
  - the `acc_width` and `stage_lat` functions;
  - the `sat_round` function.
- Each tap instantiates the existing `multiply_add`.
- Sub-module `requant` (round, ReLU, saturate, output register) is natural.

## Test plan
- Load weights 1,2,3; bias 0; SHIFT 0; image lanes (10,20,30) at t → `result` 140 with `result_valid` at t+19, and 0 at every other cycle.
- Weights −1,−1,−1; image (10,20,30):
  - with `cfg_relu`=0 → −60;
  - with `cfg_relu`=1 → 0.
- SHIFT=2, weights 1,0,0, image lane0 141 → 35. Same with lane0 −141 → −35.
- Weights 32767 ×3, images 32767 ×3, OUT_WIDTH 16 → 32767 (saturated). Weights −32768 ×3 → −32768.
- Back-to-back stream of 20 images, then `weight_clear`:
  - FSM enters DRAIN; `weight_ready` rises only after the 20th result;
  - an image sent during DRAIN sets `err_drop` and produces no result.
- `rst_n` low for 1 cycle mid-stream → outputs 0 immediately, no later `result_valid`, FSM in LOAD with `weight_ready`=1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution slice: FSM state encoding,
// derived-width helpers and the round/ReLU/saturate requantisation function.
package conv_pkg;

   typedef enum logic [1:0] {LOAD, READY, DRAIN} slice_state_t;

   // Accumulator width that cannot overflow for n taps plus a bias.
   function automatic int acc_width(input int iw, input int ww, input int n);
      return iw + ww + $clog2(n) + 1;
   endfunction

   // Per-tap latency: multiply_add pipeline plus the partial-sum register.
   function automatic int stage_lat(input int mac_lat);
      return mac_lat + 1;
   endfunction

   // Round-half-up shift, optional ReLU, then clamp to a signed out_w range.
   // Operates on 64 bits, so the accumulator must be no wider than that.
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] v,
                                                    input int shift,
                                                    input logic relu,
                                                    input int out_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = v;
      if (shift > 0) begin
         r = (v + (64'sd1 <<< (shift - 1))) >>> shift;
      end
      if (relu && (r < 64'sd0)) begin
         r = 64'sd0;
      end
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/multiply_add.sv
// Pipelined signed multiply-accumulate: o_p = i_a * i_b + i_c, LAT cycles later.
module multiply_add #(
   parameter int A_WIDTH = 16,
   parameter int B_WIDTH = 16,
   parameter int P_WIDTH = 35,
   parameter int LAT     = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [A_WIDTH-1:0] i_a,
   input  logic signed [B_WIDTH-1:0] i_b,
   input  logic signed [P_WIDTH-1:0] i_c,
   output logic signed [P_WIDTH-1:0] o_p
);

   logic signed [P_WIDTH-1:0] w_a;
   logic signed [P_WIDTH-1:0] w_b;
   logic signed [P_WIDTH-1:0] w_p;
   logic signed [P_WIDTH-1:0] r_pipe [LAT];

   // Sign-extend before multiplying so the product is exact in P_WIDTH.
   assign w_a = P_WIDTH'(i_a);
   assign w_b = P_WIDTH'(i_b);
   assign w_p = (w_a * w_b) + i_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= w_p;
         for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_p = r_pipe[LAT-1];

endmodule

// File: rtl/requant.sv
// Registered requantisation stage: round, optional ReLU, saturate to OUT_WIDTH.
// The result register holds 0 whenever the output is not valid.
module requant
   import conv_pkg::*;
#(
   parameter int ACC_WIDTH = 35,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [ACC_WIDTH-1:0] i_sum,
   input  logic                        i_valid,
   input  logic                        i_relu,
   output logic signed [OUT_WIDTH-1:0] o_result,
   output logic                        o_valid
);

   logic signed [OUT_WIDTH-1:0] r_result;
   logic                        r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_result <= OUT_WIDTH'(sat_round(64'(i_sum), SHIFT, i_relu, OUT_WIDTH));
         end else begin
            r_result <= '0;
         end
      end
   end

   assign o_result = r_result;
   assign o_valid  = r_valid;

endmodule

// File: rtl/conv_slice.sv
// Systolic MAC_NB-tap signed convolution slice with serial weight load,
// bias seeding and registered requantisation of the dot product.
module conv_slice
   import conv_pkg::*;
#(
   parameter int  MAC_NB       = 3,
   parameter int  IMAGE_WIDTH  = 16,
   parameter int  WEIGHT_WIDTH = 16,
   parameter int  MAC_LAT      = 5,
   parameter int  OUT_WIDTH    = 16,
   parameter int  SHIFT        = 0,
   localparam int ACC_WIDTH    = acc_width(IMAGE_WIDTH, WEIGHT_WIDTH, MAC_NB),
   localparam int STAGE        = stage_lat(MAC_LAT)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic signed [ACC_WIDTH-1:0]     cfg_bias,
   input  logic                            cfg_relu,
   input  logic signed [WEIGHT_WIDTH-1:0]  weight,
   input  logic                            weight_valid,
   output logic                            weight_ready,
   input  logic                            weight_clear,
   output logic                            weight_loaded,
   input  logic [IMAGE_WIDTH*MAC_NB-1:0]   image,
   input  logic                            image_valid,
   output logic signed [OUT_WIDTH-1:0]     result,
   output logic                            result_valid,
   output logic                            err_drop
);

   localparam int IDX_W    = (MAC_NB > 1) ? $clog2(MAC_NB) : 1;
   localparam int PIPE_LEN = STAGE * MAC_NB;

   slice_state_t                   r_state;
   logic [IDX_W-1:0]               r_idx;
   logic signed [WEIGHT_WIDTH-1:0] r_weight [MAC_NB];
   logic                           r_weight_ready;
   logic                           r_weight_loaded;
   logic                           r_err_drop;
   logic [PIPE_LEN-1:0]            r_vld;
   logic [PIPE_LEN-1:0]            r_relu;
   logic signed [ACC_WIDTH-1:0]    w_final;
   logic                           w_accept;
   logic                           w_busy;
   logic                           w_res_valid;

   assign w_accept = image_valid && (r_state == READY);
   assign w_busy   = (|r_vld) || w_res_valid;

   // Weight-load / drain controller with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= LOAD;
         r_idx           <= '0;
         r_weight_ready  <= 1'b1;
         r_weight_loaded <= 1'b0;
         r_err_drop      <= 1'b0;
         for (int i = 0; i < MAC_NB; i++) begin
            r_weight[i] <= '0;
         end
      end else begin
         if (image_valid && (r_state != READY)) begin
            r_err_drop <= 1'b1;
         end
         case (r_state)
            LOAD: begin
               if (weight_clear) begin
                  r_idx <= '0;
               end else if (weight_valid && r_weight_ready) begin
                  r_weight[r_idx] <= weight;
                  if (r_idx == IDX_W'(MAC_NB - 1)) begin
                     r_idx           <= '0;
                     r_state         <= READY;
                     r_weight_ready  <= 1'b0;
                     r_weight_loaded <= 1'b1;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            READY: begin
               if (weight_clear) begin
                  r_state         <= DRAIN;
                  r_weight_loaded <= 1'b0;
               end
            end
            DRAIN: begin
               if (!w_busy) begin
                  r_state        <= LOAD;
                  r_idx          <= '0;
                  r_weight_ready <= 1'b1;
               end
            end
            default: begin
               r_state         <= LOAD;
               r_idx           <= '0;
               r_weight_ready  <= 1'b1;
               r_weight_loaded <= 1'b0;
            end
         endcase
      end
   end

   // Valid and ReLU flags travel alongside the data through every tap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_relu <= '0;
      end else begin
         r_vld  <= {r_vld[PIPE_LEN-2:0], w_accept};
         r_relu <= {r_relu[PIPE_LEN-2:0], cfg_relu};
      end
   end

   for (genvar x = 0; x < MAC_NB; x++) begin : g_tap
      logic signed [IMAGE_WIDTH-1:0] w_lane;
      logic signed [IMAGE_WIDTH-1:0] w_tap_img;
      logic signed [ACC_WIDTH-1:0]   w_tap_c;
      logic signed [ACC_WIDTH-1:0]   w_mac;
      logic signed [ACC_WIDTH-1:0]   r_psum;

      assign w_lane = image[x*IMAGE_WIDTH +: IMAGE_WIDTH];

      if (x == 0) begin : g_first
         assign w_tap_img = w_lane;
         assign w_tap_c   = cfg_bias;
      end else begin : g_delay
         // Lane x waits for the partial sum to ripple through x earlier taps.
         logic signed [IMAGE_WIDTH-1:0] r_dly [STAGE*x];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < STAGE * x; i++) begin
                  r_dly[i] <= '0;
               end
            end else begin
               r_dly[0] <= w_lane;
               for (int i = 1; i < STAGE * x; i++) begin
                  r_dly[i] <= r_dly[i-1];
               end
            end
         end

         assign w_tap_img = r_dly[STAGE*x-1];
         assign w_tap_c   = g_tap[x-1].r_psum;
      end

      multiply_add #(
         .A_WIDTH (IMAGE_WIDTH),
         .B_WIDTH (WEIGHT_WIDTH),
         .P_WIDTH (ACC_WIDTH),
         .LAT     (MAC_LAT)
      ) u_mac (
         .clk   (clk),
         .rst_n (rst_n),
         .i_a   (w_tap_img),
         .i_b   (r_weight[x]),
         .i_c   (w_tap_c),
         .o_p   (w_mac)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_psum <= '0;
         end else begin
            r_psum <= w_mac;
         end
      end
   end

   assign w_final = g_tap[MAC_NB-1].r_psum;

   requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_requant (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sum    (w_final),
      .i_valid  (r_vld[PIPE_LEN-1]),
      .i_relu   (r_relu[PIPE_LEN-1]),
      .o_result (result),
      .o_valid  (w_res_valid)
   );

   assign result_valid  = w_res_valid;
   assign weight_ready  = r_weight_ready;
   assign weight_loaded = r_weight_loaded;
   assign err_drop      = r_err_drop;

endmodule

// File: tb/tb_conv_slice.sv
// Scoreboard bench for conv_slice: SHIFT=0 and SHIFT=2 instances share stimulus,
// expected results are queued at send time and popped when result_valid appears.
module tb_conv_slice;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [34:0] cfg_bias = '0;
   logic               cfg_relu = 1'b0;
   logic signed [15:0] weight = '0;
   logic               weight_valid = 1'b0;
   logic               weight_clear = 1'b0;
   logic [47:0]        image = '0;
   logic               image_valid = 1'b0;

   logic               wr0, wl0, rv0, ed0;
   logic               wr2, wl2, rv2, ed2;
   logic signed [15:0] res0, res2;

   typedef struct {
      logic signed [15:0] val;
      int                 cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   exp_t e0, e2;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   tw[3];

   conv_slice #(.SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
      .weight(weight), .weight_valid(weight_valid), .weight_ready(wr0),
      .weight_clear(weight_clear), .weight_loaded(wl0), .image(image),
      .image_valid(image_valid), .result(res0), .result_valid(rv0), .err_drop(ed0)
   );

   conv_slice #(.SHIFT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
      .weight(weight), .weight_valid(weight_valid), .weight_ready(wr2),
      .weight_clear(weight_clear), .weight_loaded(wl2), .image(image),
      .image_valid(image_valid), .result(res2), .result_valid(rv2), .err_drop(ed2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic signed [15:0] model(input int l0, input int l1, input int l2,
                                                input longint bias, input bit relu,
                                                input int sh);
      longint s;
      s = bias + longint'(l0) * tw[0] + longint'(l1) * tw[1] + longint'(l2) * tw[2];
      if (sh > 0) s = (s + (longint'(1) <<< (sh - 1))) >>> sh;
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   // Result monitor for both instances.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         total++;
         if (rv0 === 1'b1) begin
            if (q0.size() == 0) begin
               bad++;
               $display("FAIL shift0_extra got=%0d at cyc %0d expected no result", res0, cyc);
            end else begin
               e0 = q0.pop_front();
               if (res0 !== e0.val || cyc != e0.cyc) begin
                  bad++;
                  $display("FAIL shift0_result got=%0d@%0d expected=%0d@%0d",
                           res0, cyc, e0.val, e0.cyc);
               end
            end
         end else if (res0 !== 16'sd0 || rv0 !== 1'b0) begin
            bad++;
            $display("FAIL shift0_idle got=%0d valid=%b expected=0", res0, rv0);
         end else if (q0.size() != 0 && q0[0].cyc < cyc) begin
            bad++;
            $display("FAIL shift0_missing got=none expected=%0d@%0d", q0[0].val, q0[0].cyc);
            q0.delete(0);
         end
         total++;
         if (rv2 === 1'b1) begin
            if (q2.size() == 0) begin
               bad++;
               $display("FAIL shift2_extra got=%0d at cyc %0d expected no result", res2, cyc);
            end else begin
               e2 = q2.pop_front();
               if (res2 !== e2.val || cyc != e2.cyc) begin
                  bad++;
                  $display("FAIL shift2_result got=%0d@%0d expected=%0d@%0d",
                           res2, cyc, e2.val, e2.cyc);
               end
            end
         end else if (res2 !== 16'sd0 || rv2 !== 1'b0) begin
            bad++;
            $display("FAIL shift2_idle got=%0d valid=%b expected=0", res2, rv2);
         end else if (q2.size() != 0 && q2[0].cyc < cyc) begin
            bad++;
            $display("FAIL shift2_missing got=none expected=%0d@%0d", q2[0].val, q2[0].cyc);
            q2.delete(0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Image presented in cycle cyc is accepted there; result is due 19 cycles later.
   task automatic send(input int l0, input int l1, input int l2,
                       input longint bias, input bit relu);
      exp_t e;
      image       = {16'(l2), 16'(l1), 16'(l0)};
      cfg_bias    = 35'(bias);
      cfg_relu    = relu;
      image_valid = 1'b1;
      e.cyc = cyc + 19;
      e.val = model(l0, l1, l2, bias, relu, 0);
      q0.push_back(e);
      e.val = model(l0, l1, l2, bias, relu, 2);
      q2.push_back(e);
      step();
      image_valid = 1'b0;
   endtask

   task automatic load(input int w0, input int w1, input int w2);
      int w[3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      for (int i = 0; i < 3; i++) begin
         tw[i]        = w[i];
         weight       = 16'(w[i]);
         weight_valid = 1'b1;
         total++;
         if (wr0 !== 1'b1 || wr2 !== 1'b1) begin
            bad++;
            $display("FAIL load_ready tap=%0d got=%b/%b expected=1", i, wr0, wr2);
         end
         step();
      end
      weight_valid = 1'b0;
      total++;
      if (wl0 !== 1'b1 || wl2 !== 1'b1 || wr0 !== 1'b0 || wr2 !== 1'b0) begin
         bad++;
         $display("FAIL loaded_flags got=loaded %b/%b ready %b/%b expected=loaded 1 ready 0",
                  wl0, wl2, wr0, wr2);
      end
   endtask

   task automatic reload(input int w0, input int w1, input int w2);
      weight_clear = 1'b1;
      step();
      weight_clear = 1'b0;
      for (int i = 0; i < 100 && wr0 !== 1'b1; i++) step();
      total++;
      if (wr0 !== 1'b1 || wr2 !== 1'b1) begin
         bad++;
         $display("FAIL drain_timeout got=%b/%b expected=1", wr0, wr2);
      end
      load(w0, w1, w2);
   endtask

   task automatic wait_results();
      for (int i = 0; i < 200 && (q0.size() != 0 || q2.size() != 0); i++) step();
      total++;
      if (q0.size() != 0 || q2.size() != 0) begin
         bad++;
         $display("FAIL result_timeout got=%0d/%0d pending expected=0", q0.size(), q2.size());
         q0.delete();
         q2.delete();
      end
   endtask

   task automatic test_reset();
      step();
      step();
      total++;
      if (wr0 !== 1'b1 || wl0 !== 1'b0 || rv0 !== 1'b0 || res0 !== 16'sd0 || ed0 !== 1'b0 ||
          wr2 !== 1'b1 || wl2 !== 1'b0 || rv2 !== 1'b0 || res2 !== 16'sd0 || ed2 !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got=rdy%b ld%b v%b r%0d e%b expected=rdy1 ld0 v0 r0 e0",
                  wr0, wl0, rv0, res0, ed0);
      end
      rst_n = 1'b1;
      step();
      total++;
      if (wr0 !== 1'b1 || wl0 !== 1'b0) begin
         bad++;
         $display("FAIL post_reset got=rdy%b ld%b expected=rdy1 ld0", wr0, wl0);
      end
   endtask

   task automatic test_basic();
      load(1, 2, 3);
      send(10, 20, 30, 0, 1'b0);
      wait_results();
      send(10, 20, 30, 1000, 1'b0);
      wait_results();
   endtask

   task automatic test_relu();
      reload(-1, -1, -1);
      send(10, 20, 30, 0, 1'b0);
      send(10, 20, 30, 0, 1'b1);
      wait_results();
   endtask

   task automatic test_round();
      reload(1, 0, 0);
      send(141, 0, 0, 0, 1'b0);
      send(-141, 0, 0, 0, 1'b0);
      send(-6, 0, 0, 0, 1'b0);
      wait_results();
   endtask

   task automatic test_saturate();
      reload(32767, 32767, 32767);
      send(32767, 32767, 32767, 0, 1'b0);
      wait_results();
      reload(-32768, -32768, -32768);
      send(32767, 32767, 32767, 0, 1'b0);
      wait_results();
   endtask

   task automatic test_back_to_back();
      bit seen_ready;
      reload(1, 2, 3);
      for (int i = 0; i < 20; i++) begin
         send(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
              int'($urandom_range(2000)) - 1000, longint'($urandom_range(200)) - 100,
              1'(i % 3 == 0));
      end
      weight_clear = 1'b1;
      step();
      weight_clear = 1'b0;
      total++;
      if (ed0 !== 1'b0 || ed2 !== 1'b0 || wl0 !== 1'b0 || wr0 !== 1'b0) begin
         bad++;
         $display("FAIL drain_entry got=err%b ld%b rdy%b expected=err0 ld0 rdy0", ed0, wl0, wr0);
      end
      image       = {16'sd5, 16'sd5, 16'sd5};
      image_valid = 1'b1;
      step();
      image_valid = 1'b0;
      total++;
      if (ed0 !== 1'b1 || ed2 !== 1'b1) begin
         bad++;
         $display("FAIL drop_flag got=%b/%b expected=1", ed0, ed2);
      end
      seen_ready = 1'b0;
      for (int i = 0; i < 100 && !seen_ready; i++) begin
         if (wr0 === 1'b1) begin
            seen_ready = 1'b1;
            total++;
            if (q0.size() != 0) begin
               bad++;
               $display("FAIL early_ready got=ready with %0d pending expected=0", q0.size());
            end
         end else begin
            step();
         end
      end
      total++;
      if (!seen_ready) begin
         bad++;
         $display("FAIL ready_timeout got=%b expected=1", wr0);
      end
      for (int i = 0; i < 30; i++) step();
   endtask

   task automatic test_reset_midstream();
      load(1, 1, 1);
      for (int i = 0; i < 8; i++) send(i + 1, 2 * i, -i, 7, 1'b0);
      for (int i = 0; i < 12; i++) step();
      total++;
      if (rv0 !== 1'b1) begin
         bad++;
         $display("FAIL midstream_active got=%b expected=1", rv0);
      end
      rst_n = 1'b0;
      #1;
      q0.delete();
      q2.delete();
      total++;
      if (rv0 !== 1'b0 || res0 !== 16'sd0 || rv2 !== 1'b0 || res2 !== 16'sd0 ||
          wr0 !== 1'b1 || wl0 !== 1'b0 || ed0 !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got=v%b r%0d rdy%b ld%b e%b expected=v0 r0 rdy1 ld0 e0",
                  rv0, res0, wr0, wl0, ed0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) step();
      total++;
      if (wr0 !== 1'b1 || wl0 !== 1'b0 || ed0 !== 1'b0) begin
         bad++;
         $display("FAIL after_reset got=rdy%b ld%b e%b expected=rdy1 ld0 e0", wr0, wl0, ed0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_round();
      test_saturate();
      test_back_to_back();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
